// File: rtl/ifmap_gin_buffer.sv
// Elastic FIFO between the GLB ifmap read port and the GIN multicast network,
// with per-pass word accounting, fill reporting and a sticky drop error.
//   state  | meaning
//   IDLE   | waiting for i_load_start; all pushes are dropped
//   STREAM | accepting GLB words until wr_cnt reaches the expected count
//   DRAIN  | no pushes; waiting for all expected words to leave the FIFO
//   DONE   | one-cycle completion pulse, then back to IDLE
module ifmap_gin_buffer #(
    parameter int DATA_W   = 16,
    parameter int TAG_W    = 9,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = DEPTH - 2
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_load_start,
    input  logic [15:0]                i_expected_cnt,
    input  logic                       i_ifmap_valid,
    input  logic [TAG_W-1:0]           i_ifmap_tag,
    input  logic [DATA_W-1:0]          i_glb_rdata,
    output logic                       o_gin_valid,
    output logic [DATA_W-1:0]          o_gin_data,
    output logic [TAG_W-1:0]           o_gin_tag,
    input  logic                       i_gin_ready,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_almost_full,
    output logic                       o_busy,
    output logic                       o_done,
    output logic                       o_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_DRAIN  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t             state;
    logic [DATA_W-1:0]  data_mem [DEPTH];
    logic [TAG_W-1:0]   tag_mem  [DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [CW-1:0]      occ;
    logic [15:0]        exp_cnt;
    logic [15:0]        wr_cnt;
    logic [15:0]        rd_cnt;
    logic               err;

    logic empty;
    logic full;
    logic push;
    logic pop;
    logic drop;
    logic last_push;

    assign empty     = (occ == '0);
    assign full      = (occ == CW'(DEPTH));
    assign pop       = !empty && i_gin_ready;
    // A full FIFO still accepts a word when the head leaves in the same cycle.
    assign push      = (state == S_STREAM) && i_ifmap_valid && (!full || pop);
    assign drop      = i_ifmap_valid && !push;
    assign last_push = push && ((wr_cnt + 16'd1) == exp_cnt);

    always_ff @(posedge i_clk) begin
        if (push) begin
            data_mem[wr_ptr] <= i_glb_rdata;
            tag_mem[wr_ptr]  <= i_ifmap_tag;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state   <= S_IDLE;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            occ     <= '0;
            exp_cnt <= '0;
            wr_cnt  <= '0;
            rd_cnt  <= '0;
            err     <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
                wr_cnt <= wr_cnt + 16'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                rd_cnt <= rd_cnt + 16'd1;
            end

            case ({push, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase

            if (drop) begin
                err <= 1'b1;
            end else if (state == S_IDLE && i_load_start) begin
                err <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (i_load_start) begin
                        exp_cnt <= i_expected_cnt;
                        wr_cnt  <= '0;
                        rd_cnt  <= '0;
                        state   <= (i_expected_cnt == 16'd0) ? S_DONE : S_STREAM;
                    end
                end
                S_STREAM: begin
                    if (last_push) begin
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (rd_cnt == exp_cnt && empty) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Head is zeroed when empty so stale entries never leak after reset.
    assign o_gin_valid   = !empty;
    assign o_gin_data    = empty ? '0 : data_mem[rd_ptr];
    assign o_gin_tag     = empty ? '0 : tag_mem[rd_ptr];
    assign o_count       = occ;
    assign o_almost_full = (occ >= CW'(AF_LEVEL));
    assign o_busy        = (state != S_IDLE);
    assign o_done        = (state == S_DONE);
    assign o_err         = err;

endmodule

// File: tb/tb_ifmap_gin_buffer.sv
// Directed bench for ifmap_gin_buffer: basic pass, backpressure, full wrap,
// zero-length pass, illegal push and mid-pass reset.
module tb_ifmap_gin_buffer;

    logic        clk;
    logic        rst_n;
    logic        load_start;
    logic [15:0] expected_cnt;
    logic        ifmap_valid;
    logic [8:0]  ifmap_tag;
    logic [15:0] glb_rdata;
    logic        gin_valid;
    logic [15:0] gin_data;
    logic [8:0]  gin_tag;
    logic        gin_ready;
    logic [3:0]  count;
    logic        almost_full;
    logic        busy;
    logic        done;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;

    ifmap_gin_buffer #(
        .DATA_W(16), .TAG_W(9), .DEPTH(8), .AF_LEVEL(6)
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_load_start   (load_start),
        .i_expected_cnt (expected_cnt),
        .i_ifmap_valid  (ifmap_valid),
        .i_ifmap_tag    (ifmap_tag),
        .i_glb_rdata    (glb_rdata),
        .o_gin_valid    (gin_valid),
        .o_gin_data     (gin_data),
        .o_gin_tag      (gin_tag),
        .i_gin_ready    (gin_ready),
        .o_count        (count),
        .o_almost_full  (almost_full),
        .o_busy         (busy),
        .o_done         (done),
        .o_err          (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_pass(input int n);
        load_start   = 1'b1;
        expected_cnt = 16'(n);
        tick();
        load_start   = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        n_checks++;
        if ({gin_valid, gin_data, gin_tag, count, almost_full, busy, done, err} !== 34'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%b d=%h t=%h c=%0d af=%b b=%b dn=%b e=%b, expected all 0",
                     gin_valid, gin_data, gin_tag, count, almost_full, busy, done, err);
        end
        rst_n = 1'b1;
        tick();
        n_checks++;
        if (busy !== 1'b0 || gin_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: busy=%b valid=%b, expected 0 0", busy, gin_valid);
        end
    endtask

    task automatic test_basic();
        int dones = 0;
        gin_ready = 1'b1;
        start_pass(5);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_busy: got %b expected 1", busy);
        end
        for (int i = 0; i < 5; i++) begin
            ifmap_valid = 1'b1;
            glb_rdata   = 16'h0011 + 16'(i);
            ifmap_tag   = 9'h021 + 9'(i);
            tick();
            if (done === 1'b1) dones++;
            n_checks++;
            if (gin_valid !== 1'b1 || gin_data !== 16'h0011 + 16'(i) ||
                gin_tag !== 9'h021 + 9'(i) || count !== 4'd1) begin
                n_fail++;
                $display("FAIL basic_word[%0d]: got v=%b d=%h t=%h c=%0d, expected v=1 d=%h t=%h c=1",
                         i, gin_valid, gin_data, gin_tag, count, 16'h0011 + 16'(i), 9'h021 + 9'(i));
            end
        end
        ifmap_valid = 1'b0;
        tick();
        if (done === 1'b1) dones++;
        n_checks++;
        if (gin_valid !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_drained: valid=%b busy=%b, expected 0 1", gin_valid, busy);
        end
        tick();
        if (done === 1'b1) dones++;
        n_checks++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_done: got %b expected 1", done);
        end
        tick();
        if (done === 1'b1) dones++;
        n_checks++;
        if (dones != 1 || busy !== 1'b0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_end: done_pulses=%0d busy=%b err=%b, expected 1 0 0", dones, busy, err);
        end
    endtask

    task automatic test_backpressure();
        int exp_c;
        gin_ready = 1'b0;
        start_pass(10);
        for (int i = 1; i <= 10; i++) begin
            ifmap_valid = 1'b1;
            glb_rdata   = 16'h0100 + 16'(i);
            ifmap_tag   = 9'(i);
            tick();
            exp_c = (i > 8) ? 8 : i;
            n_checks++;
            if (count !== 4'(exp_c) || almost_full !== (exp_c >= 6) ||
                err !== (i > 8) || gin_data !== 16'h0101 || gin_tag !== 9'd1) begin
                n_fail++;
                $display("FAIL bp_push[%0d]: got c=%0d af=%b e=%b d=%h t=%h, expected c=%0d af=%b e=%b d=0101 t=001",
                         i, count, almost_full, err, gin_data, gin_tag, exp_c, exp_c >= 6, i > 8);
            end
        end
        ifmap_valid = 1'b0;
        tick();
        n_checks++;
        if (busy !== 1'b1 || count !== 4'd8 || err !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_hold: busy=%b c=%0d err=%b, expected 1 8 1", busy, count, err);
        end
        rst_n = 1'b0;
        tick();
        n_checks++;
        if ({gin_valid, count, busy, err, almost_full} !== 8'd0) begin
            n_fail++;
            $display("FAIL bp_reset: v=%b c=%0d b=%b e=%b af=%b, expected all 0",
                     gin_valid, count, busy, err, almost_full);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_full_wrap();
        gin_ready = 1'b0;
        start_pass(12);
        for (int i = 0; i < 8; i++) begin
            ifmap_valid = 1'b1;
            glb_rdata   = 16'h0200 + 16'(i);
            ifmap_tag   = 9'h040 + 9'(i);
            tick();
        end
        n_checks++;
        if (count !== 4'd8 || almost_full !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_fill: c=%0d af=%b, expected 8 1", count, almost_full);
        end
        gin_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            glb_rdata = 16'h0208 + 16'(j);
            ifmap_tag = 9'h048 + 9'(j);
            n_checks++;
            if (gin_data !== 16'h0200 + 16'(j)) begin
                n_fail++;
                $display("FAIL wrap_head[%0d]: got %h expected %h", j, gin_data, 16'h0200 + 16'(j));
            end
            tick();
            n_checks++;
            if (count !== 4'd8 || err !== 1'b0) begin
                n_fail++;
                $display("FAIL wrap_pushpop[%0d]: c=%0d err=%b, expected 8 0", j, count, err);
            end
        end
        ifmap_valid = 1'b0;
        for (int j = 4; j < 12; j++) begin
            n_checks++;
            if (gin_valid !== 1'b1 || gin_data !== 16'h0200 + 16'(j) || gin_tag !== 9'h040 + 9'(j)) begin
                n_fail++;
                $display("FAIL wrap_drain[%0d]: got v=%b d=%h t=%h expected v=1 d=%h t=%h",
                         j, gin_valid, gin_data, gin_tag, 16'h0200 + 16'(j), 9'h040 + 9'(j));
            end
            tick();
        end
        n_checks++;
        if (count !== 4'd0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_empty: c=%0d done=%b, expected 0 0", count, done);
        end
        tick();
        n_checks++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_done: got %b expected 1", done);
        end
        tick();
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_idle: busy=%b done=%b, expected 0 0", busy, done);
        end
    endtask

    task automatic test_zero_length();
        start_pass(0);
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b1 || gin_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_done: done=%b busy=%b valid=%b, expected 1 1 0", done, busy, gin_valid);
        end
        tick();
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0 || gin_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_idle: done=%b busy=%b valid=%b, expected 0 0 0", done, busy, gin_valid);
        end
    endtask

    task automatic test_illegal_and_reset();
        gin_ready   = 1'b0;
        ifmap_valid = 1'b1;
        glb_rdata   = 16'hdead;
        ifmap_tag   = 9'h0aa;
        tick();
        ifmap_valid = 1'b0;
        n_checks++;
        if (err !== 1'b1 || count !== 4'd0 || gin_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_push: err=%b c=%0d valid=%b, expected 1 0 0", err, count, gin_valid);
        end
        start_pass(4);
        n_checks++;
        if (err !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL start_clears_err: err=%b busy=%b, expected 0 1", err, busy);
        end
        for (int i = 0; i < 2; i++) begin
            ifmap_valid = 1'b1;
            glb_rdata   = 16'h0300 + 16'(i);
            ifmap_tag   = 9'(i);
            tick();
        end
        ifmap_valid = 1'b0;
        n_checks++;
        if (count !== 4'd2) begin
            n_fail++;
            $display("FAIL midpass_fill: c=%0d expected 2", count);
        end
        rst_n = 1'b0;
        tick();
        n_checks++;
        if ({gin_valid, gin_data, gin_tag, count, almost_full, busy, done, err} !== 34'd0) begin
            n_fail++;
            $display("FAIL midpass_reset: got v=%b d=%h t=%h c=%0d af=%b b=%b dn=%b e=%b, expected all 0",
                     gin_valid, gin_data, gin_tag, count, almost_full, busy, done, err);
        end
        rst_n     = 1'b1;
        gin_ready = 1'b1;
        start_pass(1);
        ifmap_valid = 1'b1;
        glb_rdata   = 16'h0055;
        ifmap_tag   = 9'h1ff;
        tick();
        ifmap_valid = 1'b0;
        n_checks++;
        if (gin_valid !== 1'b1 || gin_data !== 16'h0055 || gin_tag !== 9'h1ff || count !== 4'd1) begin
            n_fail++;
            $display("FAIL restart_word: got v=%b d=%h t=%h c=%0d, expected v=1 d=0055 t=1ff c=1",
                     gin_valid, gin_data, gin_tag, count);
        end
        tick();
        tick();
        n_checks++;
        if (done !== 1'b1 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL restart_done: done=%b err=%b, expected 1 0", done, err);
        end
        tick();
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL restart_idle: busy=%b expected 0", busy);
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        load_start   = 1'b0;
        expected_cnt = 16'd0;
        ifmap_valid  = 1'b0;
        ifmap_tag    = 9'd0;
        glb_rdata    = 16'd0;
        gin_ready    = 1'b0;

        test_reset();
        test_basic();
        test_backpressure();
        test_full_wrap();
        test_zero_length();
        test_illegal_and_reset();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
